wb_image_loader: RTL and testbench

- Byte-stream-to-Wishbone master that sits directly upstream of the mainboard's Wishbone slave port.
- Host framing arrives as a valid/ready byte stream from a UART or SPI front-end.
- Write frames load console ROM, GROM, cartridge ROM and VDP RAM images into the 24-bit byte address space; read frames stream that space back.
- Every frame ends with a checksum or status byte on a response stream.

---
 rtl/wb_image_loader.sv | 240 ++++++++++++++++++++++++
 tb/tb_wb_image_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_image_loader.sv
// wb_image_loader
//   Byte-stream to Wishbone master. Host frames arrive on a valid/ready byte
//   stream. Write frames (0x57) load bytes into the 24-bit byte address
//   space. Read frames (0x52) stream that space back. Every frame ends with
//   a checksum byte, or 0xEE on a bus timeout, on the response stream.
//
//   Frame: CMD, A[0:7], A[8:15], A[16:23], L hi, L lo, then (write only)
//   N = L+1 data bytes.
//
// Ports
//   clk, reset_n             clock, async active-low reset
//   in_data/in_valid/in_ready    inbound command/data byte stream (bit 0 = MSB)
//   resp_data/resp_valid/resp_ready  outbound response byte stream
//   busy                     not idle
//   error                    sticky timeout flag, cleared by next command byte
//   wb_*                     Wishbone master (8-bit data, 24-bit byte address)
module wb_image_loader #(
  parameter int unsigned ack_timeout = 255  // 1..65535
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [0:7]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [0:7]  resp_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        busy,
  output logic        error,
  output logic [0:23] wb_adr_o,
  output logic [0:7]  wb_dat_o,
  input  logic [0:7]  wb_dat_i,
  output logic        wb_we_o,
  output logic [0:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i
);

  typedef enum logic [2:0] {IDLE, HDR, WDATA, WBUS, RBUS, RRESP, FRESP, DRAIN} state_t;

  localparam logic [15:0] TMO        = 16'(ack_timeout);
  localparam logic [0:7]  CMD_WR     = 8'h57;
  localparam logic [0:7]  CMD_RD     = 8'h52;
  localparam logic [0:7]  STAT_TMO   = 8'hEE;

  state_t      state_q, state_d;
  logic [2:0]  hdr_cnt_q, hdr_cnt_d;
  logic        is_wr_q, is_wr_d;
  logic [0:23] addr_q, addr_d;
  logic [0:7]  len_hi_q, len_hi_d;
  logic [15:0] cnt_q, cnt_d;     // bytes still to move after the current one
  logic [15:0] tcnt_q, tcnt_d;   // cycles the current strobe has been high
  logic [0:7]  csum_q, csum_d;
  logic [0:7]  resp_data_q, resp_data_d;
  logic        resp_valid_q, resp_valid_d;
  logic        err_q, err_d;
  logic [0:23] adr_q, adr_d;
  logic [0:7]  dat_q, dat_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;

  logic accept, ack, tmo;

  // ack only counts while strobing; an ack on the expiry edge wins over timeout
  assign ack = stb_q & wb_ack_i;
  assign tmo = stb_q & ~wb_ack_i & (tcnt_q == TMO);

  always_comb begin
    state_d      = state_q;
    hdr_cnt_d    = hdr_cnt_q;
    is_wr_d      = is_wr_q;
    addr_d       = addr_q;
    len_hi_d     = len_hi_q;
    cnt_d        = cnt_q;
    tcnt_d       = stb_q ? tcnt_q + 16'd1 : tcnt_q;
    csum_d       = csum_q;
    resp_data_d  = resp_data_q;
    resp_valid_d = resp_valid_q;
    err_d        = err_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    stb_d        = stb_q;
    we_d         = we_q;

    in_ready = (state_q == IDLE) || (state_q == HDR) ||
               (state_q == WDATA) || (state_q == DRAIN);
    accept   = in_valid & in_ready;

    case (state_q)
      IDLE: if (accept) begin
        err_d = 1'b0;
        // unknown command bytes are swallowed without a response
        if (in_data == CMD_WR || in_data == CMD_RD) begin
          state_d   = HDR;
          hdr_cnt_d = 3'd0;
          is_wr_d   = (in_data == CMD_WR);
          csum_d    = 8'h00;
        end
      end
      HDR: if (accept) begin
        hdr_cnt_d = hdr_cnt_q + 3'd1;
        case (hdr_cnt_q)
          3'd0:    addr_d[0:7]   = in_data;
          3'd1:    addr_d[8:15]  = in_data;
          3'd2:    addr_d[16:23] = in_data;
          3'd3:    len_hi_d      = in_data;
          default: begin
            cnt_d = {len_hi_q, in_data};
            adr_d = addr_q;
            if (is_wr_q) state_d = WDATA;
            else begin
              state_d = RBUS;
              stb_d   = 1'b1;
              we_d    = 1'b0;
              tcnt_d  = 16'd1;
            end
          end
        endcase
      end
      WDATA: if (accept) begin
        dat_d   = in_data;
        csum_d  = csum_q + in_data;
        stb_d   = 1'b1;
        we_d    = 1'b1;
        tcnt_d  = 16'd1;
        state_d = WBUS;
      end
      WBUS: if (ack) begin
        stb_d = 1'b0;
        we_d  = 1'b0;
        adr_d = adr_q + 24'd1;
        if (cnt_q == 16'd0) begin
          state_d      = FRESP;
          resp_data_d  = csum_q;
          resp_valid_d = 1'b1;
        end else begin
          cnt_d   = cnt_q - 16'd1;
          state_d = WDATA;
        end
      end else if (tmo) begin
        stb_d       = 1'b0;
        we_d        = 1'b0;
        err_d       = 1'b1;
        resp_data_d = STAT_TMO;
        // the timed-out byte is already consumed; cnt_q bytes remain upstream
        if (cnt_q == 16'd0) begin
          state_d      = FRESP;
          resp_valid_d = 1'b1;
        end else state_d = DRAIN;
      end
      DRAIN: if (accept) begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd1) begin
          state_d      = FRESP;
          resp_valid_d = 1'b1;
        end
      end
      RBUS: if (ack) begin
        stb_d        = 1'b0;
        resp_data_d  = wb_dat_i;
        csum_d       = csum_q + wb_dat_i;
        resp_valid_d = 1'b1;
        state_d      = RRESP;
      end else if (tmo) begin
        stb_d        = 1'b0;
        err_d        = 1'b1;
        resp_data_d  = STAT_TMO;
        resp_valid_d = 1'b1;
        state_d      = FRESP;
      end
      RRESP: if (resp_ready) begin
        adr_d = adr_q + 24'd1;
        if (cnt_q == 16'd0) begin
          resp_data_d = csum_q;        // resp_valid stays high into FRESP
          state_d     = FRESP;
        end else begin
          cnt_d        = cnt_q - 16'd1;
          resp_valid_d = 1'b0;
          stb_d        = 1'b1;
          tcnt_d       = 16'd1;
          state_d      = RBUS;
        end
      end
      FRESP: if (resp_ready) begin
        resp_valid_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      hdr_cnt_q    <= 3'd0;
      is_wr_q      <= 1'b0;
      addr_q       <= '0;
      len_hi_q     <= '0;
      cnt_q        <= '0;
      tcnt_q       <= '0;
      csum_q       <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr_cnt_q    <= hdr_cnt_d;
      is_wr_q      <= is_wr_d;
      addr_q       <= addr_d;
      len_hi_q     <= len_hi_d;
      cnt_q        <= cnt_d;
      tcnt_q       <= tcnt_d;
      csum_q       <= csum_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
      err_q        <= err_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      stb_q        <= stb_d;
      we_q         <= we_d;
    end
  end

  assign resp_data  = resp_data_q;
  assign resp_valid = resp_valid_q;
  assign busy       = (state_q != IDLE);
  assign error      = err_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign wb_we_o    = we_q;
  assign wb_sel_o   = 1'b1;
  assign wb_stb_o   = stb_q;
  assign wb_cyc_o   = stb_q;

endmodule

// File: tb/tb_wb_image_loader.sv
// Bench for wb_image_loader: directed frames from the block description plus
// randomized write/read-back frames checked against a frame-level model.
module tb_wb_image_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [0:7]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [0:7]  resp_data;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic        busy, error;
  logic [0:23] wb_adr_o;
  logic [0:7]  wb_dat_o;
  logic [0:7]  wb_dat_i = '0;
  logic        wb_we_o;
  logic [0:0]  wb_sel_o;
  logic        wb_stb_o, wb_cyc_o, wb_ack_i;

  wb_image_loader #(.ack_timeout(255)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .resp_data(resp_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .busy(busy), .error(error),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o),
    .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // ---------------- slave model ----------------
  logic [7:0] mem [int];
  int         ack_mode = 0;   // 0: comb ack, 1: never, 2: random latency
  logic       ack_gate = 1'b1;
  int         wq_a[$];
  logic [7:0] wq_d[$];
  int         run_len = 0, last_run = 0, cyc_bad = 0;
  logic [7:0] dq[$];

  function automatic logic [7:0] rdval(input int a);
    if (mem.exists(a)) return mem[a];
    return 8'(a ^ (a >> 8) ^ 32'h5A);
  endfunction

  assign wb_ack_i = wb_stb_o & ack_gate;

  always @(negedge clk) begin
    case (ack_mode)
      0:       ack_gate = 1'b1;
      1:       ack_gate = 1'b0;
      default: ack_gate = ($urandom_range(0, 3) == 0);
    endcase
    wb_dat_i = rdval(int'(wb_adr_o));
    if (wb_cyc_o !== wb_stb_o) cyc_bad++;
    if (wb_stb_o) run_len++;
    else if (run_len != 0) begin last_run = run_len; run_len = 0; end
  end

  always @(posedge clk) begin
    if (wb_stb_o && wb_ack_i && wb_we_o) begin
      wq_a.push_back(int'(wb_adr_o));
      wq_d.push_back(wb_dat_o);
      mem[int'(wb_adr_o)] = wb_dat_o;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] b);
    int k = 0;
    in_data = b; in_valid = 1'b1;
    while (!in_ready && k < 1000) begin @(negedge clk); k++; end
    if (!in_ready) chk("send_wait", {31'd0, in_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic recv(output logic [7:0] b);
    int k = 0;
    resp_ready = 1'b1;
    while (!resp_valid && k < 1000) begin @(negedge clk); k++; end
    chk("resp_wait", {31'd0, resp_valid}, 32'd1);
    b = resp_data;
    @(posedge clk); @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input int a, input int n);
    send(cmd);
    send(8'(a >> 16)); send(8'(a >> 8)); send(8'(a));
    send(8'((n - 1) >> 8)); send(8'(n - 1));
  endtask

  // write frame of dq[0..n-1] at a: expect n sequential writes and a sum byte
  task automatic wr_frame(input int a, input int n);
    logic [7:0] s = 8'h00;
    logic [7:0] r;
    wq_a.delete(); wq_d.delete();
    send_hdr(8'h57, a, n);
    for (int i = 0; i < n; i++) begin send(dq[i]); s = s + dq[i]; end
    recv(r);
    chk("wr_resp", 32'(r), 32'(s));
    chk("wr_count", wq_a.size(), n);
    for (int i = 0; i < n && i < wq_a.size(); i++) begin
      chk("wr_adr", wq_a[i], (a + i) & 32'hFFFFFF);
      chk("wr_dat", 32'(wq_d[i]), 32'(dq[i]));
    end
    chk("wr_busy_end", {31'd0, busy}, 32'd0);
  endtask

  // read frame: expect the slave contents in address order then their sum
  task automatic rd_frame(input int a, input int n);
    logic [7:0] s = 8'h00;
    logic [7:0] e, r;
    send_hdr(8'h52, a, n);
    for (int i = 0; i < n; i++) begin
      e = rdval((a + i) & 32'hFFFFFF);
      s = s + e;
      recv(r);
      chk("rd_data", 32'(r), 32'(e));
    end
    recv(r);
    chk("rd_sum", 32'(r), 32'(s));
    chk("rd_busy_end", {31'd0, busy}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] r;
    int stable, k, a, n;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_stb", {31'd0, wb_stb_o}, 32'd0);
    chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("rst_we", {31'd0, wb_we_o}, 32'd0);
    chk("rst_adr", 32'(wb_adr_o), 32'd0);
    chk("rst_dat", 32'(wb_dat_o), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk("sel_const", 32'(wb_sel_o), 32'd1);
    reset_n = 1'b1;
    @(negedge clk);

    // three-byte write, combinational ack
    ack_mode = 0;
    dq = '{8'hAA, 8'h55, 8'h0F};
    wr_frame(32'h010010, 3);

    // two-byte read with stalled response consumer
    mem[32'h020000] = 8'h12;
    mem[32'h020001] = 8'h34;
    send_hdr(8'h52, 32'h020000, 2);
    k = 0;
    while (!resp_valid && k < 100) begin @(negedge clk); k++; end
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      if (resp_valid && resp_data == 8'h12) stable++;
      @(negedge clk);
    end
    chk("rd_hold", stable, 10);
    recv(r); chk("rd_b0", 32'(r), 32'h12);
    recv(r); chk("rd_b1", 32'(r), 32'h34);
    recv(r); chk("rd_sum46", 32'(r), 32'h46);

    // address wrap
    dq = '{8'h01, 8'h02};
    wr_frame(32'hFFFFFF, 2);

    // timeout on first byte of a two-byte write
    ack_mode = 1;
    wq_a.delete(); wq_d.delete();
    send_hdr(8'h57, 32'h003000, 2);
    send(8'h11);
    send(8'h22);
    recv(r);
    chk("tmo_resp", 32'(r), 32'hEE);
    chk("tmo_error", {31'd0, error}, 32'd1);
    chk("tmo_stb_len", last_run, 255);
    chk("tmo_no_write", wq_a.size(), 0);
    chk("tmo_busy", {31'd0, busy}, 32'd0);
    ack_mode = 0;
    @(negedge clk);
    send(8'h57);
    chk("err_clear", {31'd0, error}, 32'd0);
    send(8'h00); send(8'h30); send(8'h00); send(8'h00); send(8'h00);
    send(8'h33);
    recv(r);
    chk("post_tmo_resp", 32'(r), 32'h33);

    // unknown command dropped, then a normal read
    send(8'h00);
    chk("unk_busy", {31'd0, busy}, 32'd0);
    chk("unk_resp", {31'd0, resp_valid}, 32'd0);
    rd_frame(32'h000100, 4);

    // randomized write + read-back with random ack latency
    ack_mode = 2;
    for (int t = 0; t < 4; t++) begin
      a = (t == 0) ? 32'hFFFFFD : int'($urandom_range(0, 32'hFFFFFF));
      n = $urandom_range(1, 6);
      dq.delete();
      for (int i = 0; i < n; i++) dq.push_back(8'($urandom));
      wr_frame(a, n);
      rd_frame(a, n);
    end

    // reset while a write strobe is pending
    ack_mode = 1;
    @(negedge clk);
    send_hdr(8'h57, 32'h004000, 1);
    send(8'h77);
    k = 0;
    while (!wb_stb_o && k < 20) begin @(negedge clk); k++; end
    chk("rst_mid_stb_up", {31'd0, wb_stb_o}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_stb", {31'd0, wb_stb_o}, 32'd0);
    chk("async_cyc", {31'd0, wb_cyc_o}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    ack_mode = 0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);
    chk("post_rst_noresp", {31'd0, resp_valid}, 32'd0);

    chk("cyc_eq_stb", cyc_bad, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
